lcd_frame_writer: RTL and testbench
===================================

# lcd_frame_writer

Upstream sequencer for the I2C character-LCD path. After reset it performs the HD44780 4-bit power-up/init command sequence. Then, on each refresh request, it writes two 16-character lines to the display. It produces one byte at a time (send_buffer, rs, send) for the byte-level LCD transmitter and paces itself on that transmitter's busy_flag.

## Interface
- CLK_PER_US, default 125: clk cycles per microsecond, giving 1 us ticks at 125 MHz.
- PWR_WAIT_US, default 40000: delay after reset before the first init byte.
- CLEAR_WAIT_US, default 2000: extra delay after the clear-display command 0x01.
- GAP_US, default 50: idle gap between the end of one byte (busy falls) and the next send.
- clk  in  1  system clock.
- reset_p  in  1  asynchronous, active-high reset.
- refresh  in  1  level input; a rising edge requests one full frame write.
- text_line1  in  128  line 1 text, ASCII; [127:120] is column 0 and [7:0] is column 15.
- text_line2  in  128  line 2 text, same ordering as text_line1.
- busy_flag  in  1  from the byte transmitter; high while a byte is in flight.
- send_buffer  out  8  byte to transmit.
- rs  out  1  0 = command, 1 = data.
- send  out  1  level request to the transmitter, which detects its rising edge.
- init_done  out  1  high once the init sequence has completed; stays high until reset.
- ready  out  1  high in S_IDLE with no pending refresh.

## Operation
- Reset values: send=0, send_buffer=0x00, rs=0, init_done=0, ready=0. State is S_PWR_WAIT, byte index=0, pending=0, and all counters are 0.
- Init ROM is 6 commands in order, all sent with rs=0: 0x33, 0x32, 0x28, 0x0C, 0x01, 0x06.
- Frame is 34 bytes:
  - index 0: 0x80, rs=0.
  - index 1–16: line 1 columns 0–15, rs=1.
  - index 17: 0xC0, rs=0.
  - index 18–33: line 2 columns 0–15, rs=1.
- Text snapshot: text_line1 and text_line2 are copied into an internal 256-bit register on entry to a frame. Input changes during a frame do not affect it.
- States:
  - S_PWR_WAIT: count PWR_WAIT_US ticks, then go to S_LOAD in init mode with index 0.
  - S_LOAD: drive send_buffer and rs from the ROM or frame at the current index, then go to S_SEND.
  - S_SEND: send=1 and hold. When busy_flag=1, set send=0 and go to S_BUSY.
  - S_BUSY: wait for busy_flag=0, then go to S_GAP.
  - S_GAP: count GAP_US ticks. If the byte just sent was 0x01 with rs=0, also count CLEAR_WAIT_US. Then either increment the index and go to S_LOAD, or go to the end of sequence.
  - End of init (index 5 done): set init_done=1 and go to S_IDLE.
  - End of frame (index 33 done): go to S_IDLE.
  - S_IDLE: if pending=1 or a refresh rising edge occurs, clear pending, snapshot the text, set index=0, and go to S_LOAD in frame mode.
- Refresh edges that arrive in any state other than S_IDLE set pending=1. Multiple such edges collapse into one pending request.
- send_buffer and rs are stable from S_LOAD until S_GAP ends.
- The block has no timeout. A transmitter stuck busy stalls the block in S_BUSY until reset.
- Reset mid-operation: all state returns to reset values and the full init sequence is repeated.

## Timing
- Microsecond tick: one-cycle pulse every CLK_PER_US cycles, free-running from reset.
- Reset release to first send rising edge: PWR_WAIT_US µs (±1 tick) plus 2 cycles.
- send rises one cycle after S_LOAD.
- send falls on the first clk edge after busy_flag=1 is sampled.
- Inter-byte gap, from busy_flag falling to the next send rising: GAP_US µs ±1 tick plus 2 cycles. After the clear command it is GAP_US+CLEAR_WAIT_US µs.
- ready: combinationally (state==S_IDLE && !pending), registered with one cycle of latency.
- A refresh edge in S_IDLE gives send high within 3 cycles.

## Structure
- Shared package `lcd_pkg`:
  - HD44780 command constants: CLEAR=0x01, FUNC_4BIT_2L=0x28, DISP_ON=0x0C, ENTRY_INC=0x06, DDRAM_L1=0x80, DDRAM_L2=0xC0.
  - RS_CMD and RS_DATA.
  - The state encoding: one-hot, 6 bits.
- One sub-module, `usec_tick`: parameterised microsecond pulse generator. It is reused by the delay counters.
- The byte-select mux (index to ROM or snapshot byte) stays inline.

## Test plan
- Reset then power wait, with PWR_WAIT_US=10: the bench transmitter model raises busy 1 cycle after send rises and drops it 20 cycles later.
  - No send rises before 10 µs.
  - The sequence is exactly 0x33, 0x32, 0x28, 0x0C, 0x01, 0x06, all with rs=0.
  - init_done rises after the 6th byte.
- Clear delay: the gap after 0x01 is at least GAP_US+CLEAR_WAIT_US µs; other gaps equal GAP_US µs.
- Frame write: text_line1="HELLO WORLD     " and text_line2="0123456789ABCDEF", then pulse refresh.
  - 34 bytes follow: 0x80 (rs=0), 0x48 … 0x20 (rs=1), 0xC0 (rs=0), 0x30 … 0x46 (rs=1).
  - ready returns to 1 at the end.
- Snapshot: change text_line1 to all 0x41 after byte 3 of a frame. The frame still sends the original "HELLO…" bytes.
- Pending refresh: pulse refresh 3 times during init and during a frame. Exactly one extra frame follows each busy period.
- Reset mid-frame: assert reset_p during byte 10. Outputs return to reset values immediately, and the init sequence restarts from 0x33 after the power wait.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared constants, state encoding and init-ROM helper for the
//            I2C character-LCD frame writer.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // HD44780 commands used by the init sequence and the frame addressing
    localparam logic [7:0] WAKE_8BIT    = 8'h33;
    localparam logic [7:0] WAKE_4BIT    = 8'h32;
    localparam logic [7:0] CLEAR        = 8'h01;
    localparam logic [7:0] FUNC_4BIT_2L = 8'h28;
    localparam logic [7:0] DISP_ON      = 8'h0C;
    localparam logic [7:0] ENTRY_INC    = 8'h06;
    localparam logic [7:0] DDRAM_L1     = 8'h80;
    localparam logic [7:0] DDRAM_L2     = 8'hC0;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    // Last byte index of each sequence
    localparam logic [5:0] INIT_LAST  = 6'd5;
    localparam logic [5:0] FRAME_LAST = 6'd33;

    // One-hot sequencer states
    typedef enum logic [5:0] {
        S_PWR_WAIT = 6'b000001,
        S_LOAD     = 6'b000010,
        S_SEND     = 6'b000100,
        S_BUSY     = 6'b001000,
        S_GAP      = 6'b010000,
        S_IDLE     = 6'b100000
    } state_t;

    // Power-up init command ROM; all entries are commands
    function automatic logic [7:0] init_rom(input logic [5:0] idx);
        logic [7:0] b;
        case (idx)
            6'd0:    b = WAKE_8BIT;
            6'd1:    b = WAKE_4BIT;
            6'd2:    b = FUNC_4BIT_2L;
            6'd3:    b = DISP_ON;
            6'd4:    b = CLEAR;
            6'd5:    b = ENTRY_INC;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usec_tick.sv
`default_nettype none
// ============================================================================
// Module   : usec_tick
// Purpose  : Free-running one-cycle pulse every CLK_PER_US clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module usec_tick #(
    parameter int CLK_PER_US = 125
) (
    input  logic clk,
    input  logic reset_p,
    output logic o_tick
);

    localparam int         W      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [W-1:0] c_LAST = W'(CLK_PER_US - 1);

    logic [W-1:0] r_cnt;
    logic         r_tick;

    // Divide the clock down and emit a registered pulse on wrap
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == c_LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + W'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_frame_writer
// Purpose  : Sequences HD44780 4-bit init, then writes two 16-char lines per
//            refresh request, one byte at a time, paced by busy_flag.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int CLK_PER_US    = 125,
    parameter int PWR_WAIT_US   = 40000,
    parameter int CLEAR_WAIT_US = 2000,
    parameter int GAP_US        = 50
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic         refresh,
    input  logic [127:0] text_line1,
    input  logic [127:0] text_line2,
    input  logic         busy_flag,
    output logic [7:0]   send_buffer,
    output logic         rs,
    output logic         send,
    output logic         init_done,
    output logic         ready
);

    state_t       r_state;
    logic [5:0]   r_idx;
    logic         r_frame;        // 0 = init ROM, 1 = frame bytes
    logic         r_pending;
    logic         r_refresh_d;
    logic [255:0] r_snap;         // {line1, line2}, column 0 of line1 at MSB
    logic [31:0]  r_us_cnt;
    logic [7:0]   r_send_buffer;
    logic         r_rs;
    logic         r_send;
    logic         r_init_done;
    logic         r_ready;

    logic         w_tick;
    logic         w_rise;
    logic         w_last;
    logic         w_was_clear;
    logic [31:0]  w_gap_target;
    logic [4:0]   w_char_idx;
    logic [7:0]   w_bitpos;
    logic [7:0]   w_byte;
    logic         w_rs;

    usec_tick #(
        .CLK_PER_US (CLK_PER_US)
    ) u_usec_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .o_tick  (w_tick)
    );

    assign w_rise       = refresh & ~r_refresh_d;
    assign w_last       = r_frame ? (r_idx == FRAME_LAST) : (r_idx == INIT_LAST);
    assign w_was_clear  = (r_send_buffer == CLEAR) && (r_rs == RS_CMD);
    assign w_gap_target = w_was_clear ? 32'(GAP_US + CLEAR_WAIT_US) : 32'(GAP_US);

    // Frame indices 1..16 map to chars 0..15, 18..33 map to chars 16..31
    assign w_char_idx = (r_idx <= 6'd16) ? 5'(r_idx - 6'd1) : 5'(r_idx - 6'd2);
    assign w_bitpos   = 8'd255 - {w_char_idx, 3'b000};

    // Select the byte and register-select for the current index
    always_comb begin
        w_byte = 8'h00;
        w_rs   = RS_CMD;
        if (!r_frame) begin
            w_byte = init_rom(r_idx);
        end else if (r_idx == 6'd0) begin
            w_byte = DDRAM_L1;
        end else if (r_idx == 6'd17) begin
            w_byte = DDRAM_L2;
        end else begin
            w_byte = r_snap[w_bitpos -: 8];
            w_rs   = RS_DATA;
        end
    end

    // Main sequencer: power wait, init ROM, frame writes and refresh capture
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state       <= S_PWR_WAIT;
            r_idx         <= 6'd0;
            r_frame       <= 1'b0;
            r_pending     <= 1'b0;
            r_refresh_d   <= 1'b0;
            r_snap        <= '0;
            r_us_cnt      <= 32'd0;
            r_send_buffer <= 8'h00;
            r_rs          <= RS_CMD;
            r_send        <= 1'b0;
            r_init_done   <= 1'b0;
            r_ready       <= 1'b0;
        end else begin
            r_refresh_d <= refresh;
            r_ready     <= (r_state == S_IDLE) && !r_pending;

            // Requests arriving while busy collapse into one pending frame
            if (w_rise && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_PWR_WAIT: begin
                    if (w_tick) begin
                        if (r_us_cnt + 32'd1 >= 32'(PWR_WAIT_US)) begin
                            r_us_cnt <= 32'd0;
                            r_idx    <= 6'd0;
                            r_frame  <= 1'b0;
                            r_state  <= S_LOAD;
                        end else begin
                            r_us_cnt <= r_us_cnt + 32'd1;
                        end
                    end
                end
                S_LOAD: begin
                    r_send_buffer <= w_byte;
                    r_rs          <= w_rs;
                    r_send        <= 1'b1;
                    r_state       <= S_SEND;
                end
                S_SEND: begin
                    if (busy_flag) begin
                        r_send  <= 1'b0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!busy_flag) begin
                        r_us_cnt <= 32'd0;
                        r_state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if (r_us_cnt + 32'd1 >= w_gap_target) begin
                            r_us_cnt <= 32'd0;
                            if (w_last) begin
                                if (!r_frame) begin
                                    r_init_done <= 1'b1;
                                end
                                r_state <= S_IDLE;
                            end else begin
                                r_idx   <= r_idx + 6'd1;
                                r_state <= S_LOAD;
                            end
                        end else begin
                            r_us_cnt <= r_us_cnt + 32'd1;
                        end
                    end
                end
                S_IDLE: begin
                    if (r_pending || w_rise) begin
                        r_pending <= 1'b0;
                        r_snap    <= {text_line1, text_line2};
                        r_idx     <= 6'd0;
                        r_frame   <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_PWR_WAIT;
                end
            endcase
        end
    end

    assign send_buffer = r_send_buffer;
    assign rs          = r_rs;
    assign send        = r_send;
    assign init_done   = r_init_done;
    assign ready       = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_frame_writer
// Purpose  : Self-checking bench for lcd_frame_writer with a byte-transmitter
//            model that raises busy one cycle after send and holds it 20 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_frame_writer;

    localparam int c_CPU = 4;
    localparam int c_PWR = 10;
    localparam int c_CLR = 20;
    localparam int c_GAP = 5;

    logic         clk        = 1'b0;
    logic         reset_p    = 1'b1;
    logic         refresh    = 1'b0;
    logic         busy_flag  = 1'b0;
    logic [127:0] text_line1 = '0;
    logic [127:0] text_line2 = '0;
    logic [7:0]   send_buffer;
    logic         rs;
    logic         send;
    logic         init_done;
    logic         ready;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [8:0] byte_q [$];
    int         rise_q [$];
    int         fall_q [$];
    logic       done_q [$];
    logic       send_prev = 1'b0;
    int         bcnt      = 0;

    logic [8:0] c_init_exp [6] = '{9'h033, 9'h032, 9'h028, 9'h00C, 9'h001, 9'h006};

    lcd_frame_writer #(
        .CLK_PER_US    (c_CPU),
        .PWR_WAIT_US   (c_PWR),
        .CLEAR_WAIT_US (c_CLR),
        .GAP_US        (c_GAP)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .refresh     (refresh),
        .text_line1  (text_line1),
        .text_line2  (text_line2),
        .busy_flag   (busy_flag),
        .send_buffer (send_buffer),
        .rs          (rs),
        .send        (send),
        .init_done   (init_done),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    // Transmitter model and byte logger, evaluated on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    busy_flag = 1'b0;
                    fall_q.push_back(cyc);
                end
            end
            if (send && !send_prev) begin
                byte_q.push_back({rs, send_buffer});
                rise_q.push_back(cyc);
                done_q.push_back(init_done);
                busy_flag = 1'b1;
                bcnt      = 20;
            end
            send_prev = send;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k = 0;
        while (byte_q.size() < n && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, byte_q.size(), n);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        repeat (2) @(negedge clk);
        refresh = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [8:0] exp_frame(input int i, input logic [127:0] a,
                                             input logic [127:0] b);
        if (i == 0)  return 9'h080;
        if (i == 17) return 9'h0C0;
        if (i <= 16) return {1'b1, a[127 - 8*(i-1) -: 8]};
        return {1'b1, b[127 - 8*(i-18) -: 8]};
    endfunction

    initial begin
        logic [127:0] l1;
        logic [127:0] l2;
        int base;
        int t0;
        int g;
        int k;

        l1 = "HELLO WORLD     ";
        l2 = "0123456789ABCDEF";

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_send", send, 0);
        chk("rst_buf", send_buffer, 0);
        chk("rst_rs", rs, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_ready", ready, 0);

        // Power wait and init sequence
        reset_p = 1'b0;
        t0      = cyc;
        wait_bytes(6, "init_count");
        chk("pwr_wait_delay", (rise_q[0] - t0 >= 36) && (rise_q[0] - t0 <= 47), 1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("init_byte%0d", i), byte_q[i], c_init_exp[i]);
        end
        chk("init_done_before_last", done_q[5], 0);
        k = 0;
        while (!init_done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("init_done_set", init_done, 1);
        for (int i = 0; i < 5; i++) begin
            g = rise_q[i+1] - fall_q[i];
            if (i == 4) chk("gap_after_clear", (g >= 96) && (g <= 108), 1);
            else        chk($sformatf("gap%0d", i), (g >= 16) && (g <= 27), 1);
        end

        // Frame write with a mid-frame text change
        text_line1 = l1;
        text_line2 = l2;
        repeat (5) @(negedge clk);
        chk("ready_idle", ready, 1);
        base    = byte_q.size();
        t0      = cyc;
        refresh = 1'b1;
        wait_bytes(base + 1, "frame_start");
        chk("refresh_to_send", (rise_q[base] - t0) <= 3, 1);
        refresh = 1'b0;
        wait_bytes(base + 4, "frame_b3");
        text_line1 = {16{8'h41}};
        chk("ready_busy", ready, 0);
        wait_bytes(base + 34, "frame_count");
        repeat (80) @(negedge clk);
        chk("ready_end", ready, 1);
        chk("frame_no_extra", byte_q.size(), base + 34);
        for (int i = 0; i < 34; i++) begin
            chk($sformatf("frame_byte%0d", i), byte_q[base + i], exp_frame(i, l1, l2));
        end
        chk("frame_H", byte_q[base + 1], 9'h148);
        chk("frame_D", byte_q[base + 11], 9'h144);
        chk("frame_0", byte_q[base + 18], 9'h130);
        chk("frame_F", byte_q[base + 33], 9'h146);

        // Several refreshes during a frame yield exactly one extra frame
        text_line1 = l1;
        base = byte_q.size();
        pulse_refresh();
        wait_bytes(base + 5, "pend_b5");
        repeat (3) pulse_refresh();
        wait_bytes(base + 68, "pend_count");
        repeat (150) @(negedge clk);
        chk("pend_exact", byte_q.size(), base + 68);
        chk("pend_2nd_hdr", byte_q[base + 34], 9'h080);
        chk("pend_2nd_L", byte_q[base + 35], 9'h148);
        chk("pend_ready", ready, 1);

        // Reset during byte 10 of a frame
        base = byte_q.size();
        pulse_refresh();
        wait_bytes(base + 11, "mid_b10");
        reset_p = 1'b1;
        #1;
        chk("mid_rst_send", send, 0);
        chk("mid_rst_buf", send_buffer, 0);
        chk("mid_rst_rs", rs, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_ready", ready, 0);
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        base    = byte_q.size();
        repeat (3) pulse_refresh();
        wait_bytes(base + 3, "reinit_b3");
        repeat (3) pulse_refresh();
        wait_bytes(base + 40, "reinit_count");
        repeat (150) @(negedge clk);
        chk("reinit_exact", byte_q.size(), base + 40);
        chk("reinit_first", byte_q[base], 9'h033);
        chk("reinit_last", byte_q[base + 5], 9'h006);
        chk("reinit_frame_hdr", byte_q[base + 6], 9'h080);
        chk("reinit_frame_l2", byte_q[base + 23], 9'h0C0);
        chk("reinit_done", init_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
